// File: rtl/cbd_poly_writer_if.sv
// Sampler-to-polynomial-store bundle: coefficient group input, read port and status.
// master drives groups and read requests; slave is the polynomial store.
interface cbd_poly_writer_if #(
  parameter int CW    = 12,
  parameter int LANES = 4,
  parameter int AW    = 8,
  parameter int GW    = 6
);
  logic                  start;
  logic [LANES*CW-1:0]   coeff_in;
  logic                  coeff_valid;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [CW-1:0]         rd_data;
  logic                  busy;
  logic                  poly_done;
  logic [GW-1:0]         group_cnt;
  logic                  range_err;
  logic                  overflow_err;

  modport master (
    output start, coeff_in, coeff_valid, rd_en, rd_addr,
    input  rd_data, busy, poly_done, group_cnt, range_err, overflow_err
  );

  modport slave (
    input  start, coeff_in, coeff_valid, rd_en, rd_addr,
    output rd_data, busy, poly_done, group_cnt, range_err, overflow_err
  );
endinterface

// File: rtl/cbd_poly_writer.sv
// Stores one CBD polynomial, lanes mapped into [0,Q-1]; one group/cycle, 1-cycle read latency.
// No backpressure: groups arriving outside FILL are dropped and flagged in overflow_err.
module cbd_poly_writer #(
  parameter int N     = 256,
  parameter int LANES = 4,
  parameter int CW    = 12,
  parameter int Q     = 3329,
  parameter int ETA   = 3
) (
  input logic              clk,
  input logic              reset,
  cbd_poly_writer_if.slave bus
);
  localparam int WORDS = N / LANES;
  localparam int GW    = $clog2(WORDS);
  localparam int LW    = $clog2(LANES);
  localparam logic signed [CW-1:0] ETA_S = CW'(ETA);
  localparam logic [CW-1:0]        Q_C   = CW'(Q);
  localparam logic [GW-1:0]        LAST  = GW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                   state;
  logic [LANES-1:0][CW-1:0] mem [WORDS];
  logic [LANES-1:0][CW-1:0] lanes_in;
  logic [LANES-1:0][CW-1:0] mapped;
  logic                     lane_bad;
  logic                     wr;
  logic signed [CW-1:0]     v;
  logic [GW-1:0]            cnt;
  logic [CW-1:0]            rd_q;
  logic                     busy_q, done_q, rerr_q, oerr_q;

  assign lanes_in         = bus.coeff_in;
  assign wr               = (state == FILL) && bus.coeff_valid && !bus.start;
  assign bus.group_cnt    = cnt;
  assign bus.rd_data      = rd_q;
  assign bus.busy         = busy_q;
  assign bus.poly_done    = done_q;
  assign bus.range_err    = rerr_q;
  assign bus.overflow_err = oerr_q;

  // Negative lanes wrap by adding Q modulo 2^CW; out-of-range lanes are still stored.
  always_comb begin
    mapped   = '0;
    lane_bad = 1'b0;
    v        = '0;
    for (int k = 0; k < LANES; k++) begin
      v         = lanes_in[k];
      mapped[k] = v[CW-1] ? (lanes_in[k] + Q_C) : lanes_in[k];
      if (v > ETA_S || v < -ETA_S) lane_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[cnt] <= mapped;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rerr_q <= 1'b0;
      oerr_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (bus.rd_en) rd_q <= mem[bus.rd_addr[LW +: GW]][bus.rd_addr[LW-1:0]];
      // start beats a coincident group in every state; that group is silently dropped.
      if (bus.start) begin
        state  <= FILL;
        cnt    <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
        rerr_q <= 1'b0;
        oerr_q <= 1'b0;
      end else if (bus.coeff_valid) begin
        if (state == FILL) begin
          cnt <= cnt + GW'(1);
          if (lane_bad) rerr_q <= 1'b1;
          if (cnt == LAST) begin
            state  <= FULL;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          oerr_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cbd_poly_writer.sv
// Directed bench for cbd_poly_writer: spec-level model checked every cycle plus literal spot checks.
module tb_cbd_poly_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbd_poly_writer_if bus ();
  cbd_poly_writer dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = IDLE, 1 = FILL, 2 = FULL.
  int m_mem [256];
  bit m_known [256];
  int m_phase, m_cnt, m_rd;
  bit m_rerr, m_oerr, m_rd_known;
  bit checking = 1'b0;

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] pack(int a, int b, int c, int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_rerr = 0; m_oerr = 0;
    m_rd = 0; m_rd_known = 1;
  endtask

  task automatic model_update(bit s, bit v, logic [47:0] d, bit re, logic [7:0] a);
    logic signed [11:0] lv;
    int val;
    if (re) begin
      m_rd_known = m_known[a];
      m_rd = m_mem[a];
    end
    if (s) begin
      m_phase = 1; m_cnt = 0; m_rerr = 0; m_oerr = 0;
    end else if (v) begin
      if (m_phase == 1) begin
        for (int k = 0; k < 4; k++) begin
          lv  = d[12*k +: 12];
          val = int'(lv);
          m_mem[m_cnt*4 + k]   = (val < 0) ? ((val + 3329) % 4096) : val;
          m_known[m_cnt*4 + k] = 1;
          if (val > 3 || val < -3) m_rerr = 1;
        end
        m_cnt++;
        if (m_cnt == 64) begin
          m_cnt = 0;
          m_phase = 2;
        end
      end else begin
        m_oerr = 1;
      end
    end
  endtask

  // Inputs applied 2 time units after an edge; model advanced at the next edge.
  task automatic cyc(bit s, bit v, logic [47:0] d, bit re, logic [7:0] a);
    bus.start = s; bus.coeff_valid = v; bus.coeff_in = d;
    bus.rd_en = re; bus.rd_addr = a;
    @(posedge clk);
    model_update(s, v, d, re, a);
    #2;
    bus.start = 0; bus.coeff_valid = 0; bus.rd_en = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0);
  endtask

  task automatic rd(int a);
    cyc(0, 0, '0, 1, 8'(a));
  endtask

  always @(negedge clk) begin
    if (checking && !reset) begin
      chk("busy", int'(bus.busy), int'(m_phase == 1));
      chk("poly_done", int'(bus.poly_done), int'(m_phase == 2));
      chk("group_cnt", int'(bus.group_cnt), m_cnt);
      chk("range_err", int'(bus.range_err), int'(m_rerr));
      chk("overflow_err", int'(bus.overflow_err), int'(m_oerr));
      if (m_rd_known) chk("rd_data", int'(bus.rd_data), m_rd);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    model_reset();
    bus.start = 0; bus.coeff_valid = 0; bus.coeff_in = '0;
    bus.rd_en = 0; bus.rd_addr = '0;
    reset = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.poly_done), 0);
    chk("rst_cnt", int'(bus.group_cnt), 0);
    chk("rst_rerr", int'(bus.range_err), 0);
    chk("rst_oerr", int'(bus.overflow_err), 0);
    chk("rst_rd", int'(bus.rd_data), 0);
    reset = 0;
    checking = 1;

    // Normal fill, every lane = group index mod 4.
    cyc(1, 0, '0, 0, '0);
    for (int g = 0; g < 64; g++) cyc(0, 1, pack(g % 4, g % 4, g % 4, g % 4), 0, '0);
    #1;
    chk("fill_done", int'(bus.poly_done), 1);
    chk("fill_cnt", int'(bus.group_cnt), 0);
    chk("fill_busy", int'(bus.busy), 0);
    for (int a = 0; a < 256; a++) rd(a);
    chk("lit_addr255", int'(bus.rd_data), 3);
    rd(5);
    chk("lit_addr5", int'(bus.rd_data), 1);
    idle(2);

    // Overflow in FULL; word 0 unchanged.
    cyc(0, 1, pack(3, 3, 3, 3), 0, '0);
    rd(0);
    chk("ovf_word0", int'(bus.rd_data), 0);
    chk("ovf_flag", int'(bus.overflow_err), 1);

    // Restart, negative mapping and range error.
    cyc(1, 0, '0, 0, '0);
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_oerr", int'(bus.overflow_err), 0);
    cyc(0, 1, 48'h003_000_FFF_FFD, 0, '0);
    rd(0); chk("neg_l0", int'(bus.rd_data), 3326);
    rd(1); chk("neg_l1", int'(bus.rd_data), 3328);
    rd(2); chk("neg_l2", int'(bus.rd_data), 0);
    rd(3); chk("neg_l3", int'(bus.rd_data), 3);
    chk("neg_rerr", int'(bus.range_err), 0);
    cyc(0, 1, pack(4, 0, 0, 0), 0, '0);
    rd(4); chk("big_l0", int'(bus.rd_data), 4);
    chk("big_rerr", int'(bus.range_err), 1);

    // Remaining groups with sparse strobes.
    for (int g = 2; g < 64; g++) begin
      cyc(0, 1, pack((g % 7) - 3, ((g + 1) % 7) - 3, ((g + 2) % 7) - 3, ((g + 3) % 7) - 3), 0, '0);
      idle($urandom_range(0, 5));
    end
    #1;
    chk("sparse_done", int'(bus.poly_done), 1);
    chk("sparse_rerr_sticky", int'(bus.range_err), 1);
    for (int a = 0; a < 256; a += 7) rd(a);

    // Abort after 10 groups, then read-before-write on word 0.
    cyc(1, 0, '0, 0, '0);
    for (int g = 0; g < 10; g++) cyc(0, 1, pack(g % 3, 1, -2, 0), 0, '0);
    cyc(1, 0, '0, 0, '0);
    chk("abort_cnt", int'(bus.group_cnt), 0);
    cyc(0, 1, pack(2, 2, 2, 2), 1, 8'd0);
    rd(0); chk("abort_word0", int'(bus.rd_data), 2);
    rd(4); rd(40); rd(41);

    // start coincident with a group: dropped, no overflow.
    cyc(1, 1, pack(1, 1, 1, 1), 0, '0);
    chk("coll_cnt", int'(bus.group_cnt), 0);
    chk("coll_oerr", int'(bus.overflow_err), 0);
    cyc(0, 1, pack(-1, 5, 0, 0), 0, '0);
    cyc(0, 1, pack(1, 1, 1, 1), 0, '0);
    rd(0); chk("coll_word0", int'(bus.rd_data), 3328);
    rd(4); chk("coll_word1", int'(bus.rd_data), 1);

    // Async reset mid-FILL, between edges.
    #1;
    reset = 1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.poly_done), 0);
    chk("arst_cnt", int'(bus.group_cnt), 0);
    chk("arst_rerr", int'(bus.range_err), 0);
    chk("arst_oerr", int'(bus.overflow_err), 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 0;
    cyc(0, 1, pack(0, 0, 0, 0), 0, '0);
    chk("idle_ovf", int'(bus.overflow_err), 1);
    rd(1); chk("persist_l1", int'(bus.rd_data), 5);
    idle(2);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
